// File: rtl/blackjack_table_if.sv
// Card handshake between the table FSM
// and the card RNG.
interface blackjack_table_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_value;

  modport master (
    output card_req,
    input  card_valid,
    input  card_value
  );

  modport slave (
    input  card_req,
    output card_valid,
    output card_value
  );
endinterface

// File: rtl/blackjack_table_fsm.sv
// Multi-seat blackjack table: deal, seat
// turns, dealer play and round resolution.
module blackjack_table_fsm #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 6,
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   deal_pressed,
  input  logic                   hit_pressed,
  input  logic                   stand_pressed,
  blackjack_table_if.master      card,
  output logic [NUM_PLAYERS*SCORE_W-1:0]
                                 player_scores,
  output logic [SCORE_W-1:0]     dealer_score,
  output logic                   show_dealer_first,
  output logic [1:0]             active_player,
  output logic [2:0]             game_state,
  output logic [NUM_PLAYERS*2-1:0]
                                 results,
  output logic                   round_done
);

  localparam int NH = NUM_PLAYERS + 1;
  localparam logic [2:0] DLR =
    3'(NUM_PLAYERS);
  localparam logic [1:0] LAST =
    2'(NUM_PLAYERS - 1);
  localparam logic [3:0] TOTAL =
    4'(2 * NH);
  localparam logic [SCORE_W-1:0] BUST_S =
    SCORE_W'(BUST_LIMIT);
  localparam logic [SCORE_W-1:0] STAND_S =
    SCORE_W'(DEALER_STAND);
  localparam logic [SCORE_W-1:0] TEN =
    SCORE_W'(10);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL    = 3'd1,
    PLAYER  = 3'd2,
    DEALER  = 3'd3,
    RESOLVE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [NH-1:0][SCORE_W-1:0] hard_q;
  logic [NH-1:0][SCORE_W-1:0] best;
  logic [NH-1:0]              ace_q;

  logic                   req_q;
  logic [3:0]             cnt_q;
  logic [1:0]             seat_q;
  logic                   show_q;
  logic                   done_q;
  logic [3:0]             up_q;
  logic [NUM_PLAYERS*2-1:0] res_q, res_d;

  logic                   accept;
  logic                   start;
  logic                   finish;
  logic                   req_set;
  logic [2:0]             tgt;
  logic [2:0]             add_idx;
  logic [SCORE_W-1:0]     act_best;
  logic                   act_bust;
  logic                   all_bust;
  logic                   dlr_bust;
  logic [SCORE_W-1:0]     up_best;

  assign accept = req_q & card.card_valid
                & (card.card_value != 4'd0)
                & (card.card_value <= 4'd10);

  // Ace counts as 11 only while that
  // keeps the hand within the limit.
  always_comb begin
    best = '0;
    for (int i = 0; i < NH; i++) begin
      if (ace_q[i] &&
          (hard_q[i] + TEN) <= BUST_S)
        best[i] = hard_q[i] + TEN;
      else
        best[i] = hard_q[i];
    end
  end

  always_comb begin
    tgt = (cnt_q > 4'(NUM_PLAYERS))
        ? 3'(cnt_q - 4'(NH))
        : 3'(cnt_q);
    case (state_q)
      DEAL:    add_idx = tgt;
      PLAYER:  add_idx = {1'b0, seat_q};
      default: add_idx = DLR;
    endcase
  end

  always_comb begin
    act_best = '0;
    all_bust = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (seat_q == 2'(i))
        act_best = best[i];
      if (hard_q[i] <= BUST_S)
        all_bust = 1'b0;
    end
    act_bust = act_best > BUST_S;
    dlr_bust = hard_q[NUM_PLAYERS] > BUST_S;
  end

  always_comb begin
    res_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (hard_q[i] > BUST_S)
        res_d[2*i +: 2] = 2'b10;
      else if (dlr_bust)
        res_d[2*i +: 2] = 2'b01;
      else if (best[i] > best[NUM_PLAYERS])
        res_d[2*i +: 2] = 2'b01;
      else if (best[i] < best[NUM_PLAYERS])
        res_d[2*i +: 2] = 2'b10;
      else
        res_d[2*i +: 2] = 2'b11;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    req_set = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (deal_pressed) begin
          start   = 1'b1;
          state_d = DEAL;
        end
      end
      DEAL: begin
        if (accept && cnt_q == TOTAL - 4'd1)
          state_d = PLAYER;
        else if (!req_q)
          req_set = 1'b1;
      end
      PLAYER: begin
        if (!req_q) begin
          if (stand_pressed || act_bust ||
              act_best == BUST_S) begin
            finish = 1'b1;
            if (seat_q == LAST)
              state_d = all_bust ? RESOLVE
                                 : DEALER;
          end else if (hit_pressed) begin
            req_set = 1'b1;
          end
        end
      end
      DEALER: begin
        if (!req_q) begin
          if (best[NUM_PLAYERS] >= STAND_S)
            state_d = RESOLVE;
          else
            req_set = 1'b1;
        end
      end
      RESOLVE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hard_q <= '0;
      ace_q  <= '0;
      req_q  <= 1'b0;
      cnt_q  <= '0;
      seat_q <= '0;
      show_q <= 1'b0;
      done_q <= 1'b0;
      up_q   <= '0;
      res_q  <= '0;
    end else begin
      if (accept)       req_q <= 1'b0;
      else if (req_set) req_q <= 1'b1;

      if (start) begin
        hard_q <= '0;
        ace_q  <= '0;
        cnt_q  <= '0;
        seat_q <= '0;
        up_q   <= '0;
        res_q  <= '0;
        show_q <= 1'b1;
      end else if (accept) begin
        for (int i = 0; i < NH; i++) begin
          if (add_idx == 3'(i)) begin
            hard_q[i] <= hard_q[i]
              + SCORE_W'(card.card_value);
            if (card.card_value == 4'd1)
              ace_q[i] <= 1'b1;
          end
        end
        if (state_q == DEAL) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(NUM_PLAYERS))
            up_q <= card.card_value;
        end
      end

      if (finish && seat_q != LAST)
        seat_q <= seat_q + 2'd1;
      if (state_q == PLAYER &&
          state_d != PLAYER)
        show_q <= 1'b0;
      if (state_q == RESOLVE)
        res_q <= res_d;
      done_q <= (state_q == RESOLVE);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++)
      player_scores[i*SCORE_W +: SCORE_W] =
        best[i];
  end

  assign up_best = (up_q == 4'd1)
                 ? SCORE_W'(11)
                 : SCORE_W'(up_q);

  assign dealer_score = show_q ? up_best
                      : best[NUM_PLAYERS];
  assign card.card_req     = req_q;
  assign show_dealer_first = show_q;
  assign active_player     = seat_q;
  assign game_state        = state_q;
  assign results           = res_q;
  assign round_done        = done_q;

endmodule

// File: tb/tb_blackjack_table_fsm.sv
// Directed bench for blackjack_table_fsm
// with two seats and hand-computed rounds.
module tb_blackjack_table_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       deal_pressed = 1'b0;
  logic       hit_pressed = 1'b0;
  logic       stand_pressed = 1'b0;
  logic [11:0] player_scores;
  logic [5:0] dealer_score;
  logic       show_dealer_first;
  logic [1:0] active_player;
  logic [2:0] game_state;
  logic [3:0] results;
  logic       round_done;

  int n_chk = 0;
  int n_err = 0;

  blackjack_table_if bif ();

  blackjack_table_fsm #(
    .NUM_PLAYERS (2),
    .SCORE_W     (6),
    .DEALER_STAND(17),
    .BUST_LIMIT  (21)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .deal_pressed     (deal_pressed),
    .hit_pressed      (hit_pressed),
    .stand_pressed    (stand_pressed),
    .card             (bif),
    .player_scores    (player_scores),
    .dealer_score     (dealer_score),
    .show_dealer_first(show_dealer_first),
    .active_player    (active_player),
    .game_state       (game_state),
    .results          (results),
    .round_done       (round_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int p_score(input int i);
    return int'(player_scores[i*6 +: 6]);
  endfunction

  task automatic press(input bit d,
                       input bit h,
                       input bit s);
    deal_pressed  = d;
    hit_pressed   = h;
    stand_pressed = s;
    @(negedge clk);
    deal_pressed  = 1'b0;
    hit_pressed   = 1'b0;
    stand_pressed = 1'b0;
  endtask

  task automatic give_card(input logic [3:0] v);
    int n = 0;
    while (!bif.card_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.card_req) begin
      check("req_timeout", 0, 1);
      return;
    end
    bif.card_valid = 1'b1;
    bif.card_value = v;
    @(negedge clk);
    bif.card_valid = 1'b0;
    bif.card_value = 4'd0;
  endtask

  task automatic raw_card(input logic [3:0] v);
    bif.card_valid = 1'b1;
    bif.card_value = v;
    @(negedge clk);
    bif.card_valid = 1'b0;
    bif.card_value = 4'd0;
  endtask

  task automatic deal6(input logic [3:0] a,
                       input logic [3:0] b,
                       input logic [3:0] c,
                       input logic [3:0] d,
                       input logic [3:0] e,
                       input logic [3:0] f);
    press(1'b1, 1'b0, 1'b0);
    give_card(a);
    give_card(b);
    give_card(c);
    give_card(d);
    give_card(e);
    give_card(f);
  endtask

  task automatic wait_state(input int s,
                            input int budget);
    int n = 0;
    while (int'(game_state) != s &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", game_state, s);
  endtask

  initial begin
    int pulses;
    int saw_req;
    int saw_dlr;
    int n;

    bif.card_valid = 1'b0;
    bif.card_value = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_state", game_state, 0);
    check("rst_req", bif.card_req, 0);
    check("rst_p0", p_score(0), 0);
    check("rst_p1", p_score(1), 0);
    check("rst_dlr", dealer_score, 0);
    check("rst_res", results, 0);
    check("rst_show", show_dealer_first, 0);
    check("rst_act", active_player, 0);
    check("rst_done", round_done, 0);

    // Round 1: both seats stand, dealer 19
    press(1'b0, 1'b1, 1'b1);
    check("idle_ign", game_state, 0);
    press(1'b1, 1'b0, 1'b0);
    check("r1_deal", game_state, 1);
    check("r1_show", show_dealer_first, 1);
    give_card(4'd10);
    give_card(4'd9);
    give_card(4'd7);
    give_card(4'd8);
    give_card(4'd5);
    give_card(4'd3);
    check("r1_play", game_state, 2);
    check("r1_act0", active_player, 0);
    check("r1_p0", p_score(0), 18);
    check("r1_p1", p_score(1), 14);
    check("r1_upcard", dealer_score, 7);
    press(1'b1, 1'b0, 1'b1);
    check("r1_act1", active_player, 1);
    press(1'b0, 1'b0, 1'b1);
    check("r1_dealer", game_state, 3);
    check("r1_unhide", show_dealer_first, 0);
    check("r1_dlr10", dealer_score, 10);
    give_card(4'd9);
    check("r1_dlr19", dealer_score, 19);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(round_done);
    end
    check("r1_pulses", pulses, 1);
    check("r1_done", game_state, 5);
    check("r1_res", results, 4'b1010);

    // Round 2: soft ace then all seats bust
    deal6(4'd1, 4'd10, 4'd5, 4'd6, 4'd6, 4'd2);
    check("r2_soft", p_score(0), 17);
    check("r2_p1", p_score(1), 16);
    press(1'b0, 1'b1, 1'b0);
    give_card(4'd10);
    check("r2_hard", p_score(0), 17);
    check("r2_act0", active_player, 0);
    press(1'b0, 1'b1, 1'b0);
    give_card(4'd5);
    check("r2_bust", p_score(0), 22);
    @(negedge clk);
    check("r2_adv", active_player, 1);
    press(1'b0, 1'b1, 1'b0);
    give_card(4'd10);
    check("r2_p1b", p_score(1), 26);
    saw_req = 0;
    saw_dlr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw_req |= int'(bif.card_req);
      if (game_state == 3'd3) saw_dlr = 1;
    end
    check("r2_noreq", saw_req, 0);
    check("r2_nodlr", saw_dlr, 0);
    check("r2_done", game_state, 5);
    check("r2_res", results, 4'b1010);
    check("r2_show", show_dealer_first, 0);

    // Round 3: hit+stand, illegal cards
    deal6(4'd2, 4'd3, 4'd10, 4'd3, 4'd4, 4'd6);
    check("r3_p0", p_score(0), 5);
    check("r3_up", dealer_score, 10);
    press(1'b0, 1'b1, 1'b1);
    check("r3_hs_act", active_player, 1);
    check("r3_hs_req", bif.card_req, 0);
    check("r3_hs_p0", p_score(0), 5);
    press(1'b0, 1'b1, 1'b0);
    check("r3_req", bif.card_req, 1);
    press(1'b0, 1'b1, 1'b0);
    raw_card(4'd0);
    check("r3_ill0", bif.card_req, 1);
    raw_card(4'd12);
    check("r3_ill12", bif.card_req, 1);
    check("r3_p1keep", p_score(1), 7);
    give_card(4'd4);
    check("r3_p1", p_score(1), 11);
    @(negedge clk);
    check("r3_onecard", bif.card_req, 0);
    check("r3_p1same", p_score(1), 11);
    press(1'b0, 1'b0, 1'b1);
    check("r3_dealer", game_state, 3);
    give_card(4'd10);
    check("r3_dbust", dealer_score, 26);
    wait_state(5, 10);
    check("r3_res", results, 4'b0101);

    // Round 4: push and automatic 21
    deal6(4'd10, 4'd10, 4'd10, 4'd7, 4'd1, 4'd7);
    check("r4_p1", p_score(1), 21);
    press(1'b0, 1'b0, 1'b1);
    check("r4_act1", active_player, 1);
    wait_state(5, 10);
    check("r4_dlr", dealer_score, 17);
    check("r4_res", results, 4'b0111);

    // Round 5: reset mid-dealer draw
    deal6(4'd10, 4'd10, 4'd2, 4'd5, 4'd6, 4'd3);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    n = 0;
    while (!bif.card_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("r5_req", bif.card_req, 1);
    check("r5_dealer", game_state, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r5_state", game_state, 0);
    check("r5_reqclr", bif.card_req, 0);
    check("r5_p0", p_score(0), 0);
    check("r5_p1", p_score(1), 0);
    check("r5_dlr", dealer_score, 0);
    check("r5_res", results, 0);
    check("r5_show", show_dealer_first, 0);
    deal6(4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7);
    check("r5_play", game_state, 2);
    check("r5_np0", p_score(0), 7);
    check("r5_np1", p_score(1), 9);
    check("r5_nup", dealer_score, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
